// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Optional two's-complement input, valid/ready on both sides, overflow flag.
module bin2bcd_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5,
    parameter int SIGNED     = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [4*DIGITS-1:0]            bcd,
    output logic                           sign,
    output logic                           overflow,
    output logic [$clog2(DIGITS+1)-1:0]    digit_cnt
);

    localparam int NW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int KW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_nx;
    logic [NW-1:0]         dig;
    logic [NW-1:0]         adj;
    logic [NW-1:0]         dig_nx;
    logic [KW-1:0]         cnt;
    logic                  ovf_acc;
    logic                  sign_acc;
    logic                  carry;
    logic                  last;
    logic                  neg;
    logic [DATA_WIDTH-1:0] mag;
    logic [CW-1:0]         dcnt_nx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (cnt == KW'(DATA_WIDTH - 1));

    // The most negative input negates to itself, which is the correct
    // unsigned magnitude 2^(DATA_WIDTH-1).
    always_comb begin
        neg = (SIGNED != 0) && data_in[DATA_WIDTH-1];
        mag = neg ? -data_in : data_in;
    end

    always_comb begin
        adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (dig[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = dig[4*d +: 4] + 4'd3;
            else
                adj[4*d +: 4] = dig[4*d +: 4];
        end
    end

    // Carry out of the top digit drops exactly 10^DIGITS from the result.
    always_comb begin
        carry  = adj[NW-1];
        dig_nx = {adj[NW-2:0], sr[DATA_WIDTH-1]};
        sr_nx  = {sr[DATA_WIDTH-2:0], 1'b0};
    end

    always_comb begin
        dcnt_nx = CW'(1);
        for (int d = 0; d < DIGITS; d++) begin
            if (dig_nx[4*d +: 4] != 4'd0)
                dcnt_nx = CW'(d + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            dig       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            sign_acc  <= 1'b0;
            bcd       <= '0;
            sign      <= 1'b0;
            overflow  <= 1'b0;
            digit_cnt <= CW'(1);
        end else begin
            if (state == IDLE && in_valid) begin
                sr       <= mag;
                sign_acc <= neg;
                dig      <= '0;
                ovf_acc  <= 1'b0;
                cnt      <= '0;
            end else if (state == SHIFT) begin
                sr      <= sr_nx;
                dig     <= dig_nx;
                ovf_acc <= ovf_acc | carry;
                cnt     <= cnt + 1'b1;
                if (last) begin
                    bcd       <= dig_nx;
                    sign      <= sign_acc;
                    overflow  <= ovf_acc | carry;
                    digit_cnt <= dcnt_nx;
                end
            end
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock. It generalises the fixed 16-bit/4-digit converter in four ways:
- configurable input width and digit count;
- optional two's-complement input;
- valid/ready handshakes on both sides;
- overflow and significant-digit-count outputs.

It sits between datapath counters/ADC results and the seven-segment/UART display formatters.

Parameters:
DATA_WIDTH, 16, input binary width in bits; legal range 4..32.
DIGITS, 5, number of BCD output digits; legal range 1..10.
SIGNED, 0, 1 = data_in is two's complement (magnitude converted, sign reported separately); 0 = unsigned.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  data_in is valid this cycle.
in_ready  output  1  converter can accept a value; high only in IDLE.
data_in  input  DATA_WIDTH  binary value to convert.
out_valid  output  1  result outputs are valid.
out_ready  input  1  downstream accepts the result.
bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bcd[3:0].
sign  output  1  1 = negative input (SIGNED=1 only; tied 0 when SIGNED=0).
overflow  output  1  magnitude was >= 10^DIGITS; bcd then holds magnitude mod 10^DIGITS.
digit_cnt  output  clog2(DIGITS+1)  index of the most significant nonzero digit plus 1; equals 1 for a value of 0.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE. Shift counter, working registers, bcd, sign and overflow all go to 0; digit_cnt goes to 1; out_valid goes to 0. in_ready = 1 because it is decoded from state == IDLE.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch the magnitude into the shift register. When SIGNED=1 and data_in MSB = 1, the magnitude is the two's-complement negation, and a sign flag is captured.
  - Clear the digit accumulator, overflow accumulator and shift counter, then go to SHIFT.
  - While in_valid is low, remain in IDLE.
- SHIFT, one step per cycle for exactly DATA_WIDTH cycles, counter running 0..DATA_WIDTH-1:
  - Each digit >= 5 gets +3, computed combinationally in the same cycle.
  - The whole {digits, shift register} concatenation then shifts left by 1; the shift register MSB enters digit 0 bit 0.
  - A 1 shifted out of the top digit's bit 3 sets the overflow accumulator (sticky).
  - On the step with counter == DATA_WIDTH-1: register the final digits, sign, overflow and digit_cnt into the output registers, and go to DONE.
- The most negative input (e.g. 0x8000 at 16 bits) has magnitude 2^(DATA_WIDTH-1). This fits the DATA_WIDTH-bit shift register and must convert correctly.
- DONE:
  - out_valid = 1; bcd, sign, overflow and digit_cnt are stable for as long as out_valid is high.
  - On out_valid && out_ready, go to IDLE the next cycle and drop out_valid.
  - Output registers keep the last result after the handshake, until the next DONE load.
- Latency: the acceptance edge is E0. out_valid is high after edge E(DATA_WIDTH). With out_ready held high, the minimum issue interval is DATA_WIDTH+2 cycles.
- Inputs outside IDLE:
  - in_valid during SHIFT or DONE is ignored, because in_ready = 0.
  - data_in changes after acceptance do not affect the result.
- Reset mid-SHIFT or mid-DONE aborts the conversion with no output. The first conversion after reset release is fully correct.
- digit_cnt is computed from the final digits only. It is not reduced by overflow.
- All outputs come straight from registers or from the state decode; there is no combinational path from data_in to the outputs.

Test Plan:
- Unsigned max, DATA_WIDTH=16, DIGITS=5: data_in=0xFFFF -> bcd=0x65535, digit_cnt=5, overflow=0, sign=0. out_valid high exactly 16 cycles after the acceptance edge.
- Zero and small values: data_in=0 -> bcd=0x00000, digit_cnt=1. data_in=9 -> bcd=0x00009, digit_cnt=1. data_in=10 -> bcd=0x00010, digit_cnt=2.
- SIGNED=1, 16-bit: 0x8000 -> sign=1, bcd=0x32768. 0xFFFF -> sign=1, bcd=0x00001. 0x7FFF -> sign=0, bcd=0x32767.
- Overflow, DIGITS=4: data_in=12345 -> bcd=0x2345, overflow=1, digit_cnt=4. data_in=9999 -> bcd=0x9999, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, and pulse in_valid with new data throughout. Required: outputs unchanged, in_ready=0, new data not accepted. Raising out_ready completes the handshake, and in_ready=1 on the following cycle.
- Reset mid-SHIFT at step 7 of 0x1234 -> all outputs at reset values immediately. Then convert 4660 -> bcd=0x04660. Back-to-back random values with out_ready=1 must be spaced DATA_WIDTH+2 cycles apart, with every result matching the reference model.
